seq_sub_16: RTL and testbench



---
 rtl/seq_sub_16_if.sv | 28 ++
 rtl/seq_sub_16.sv | 133 +++++++++++++
 tb/tb_seq_sub_16.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_sub_16_if.sv
// rtl/seq_sub_16_if.sv - operand/result/handshake bundle for seq_sub_16
//
// Signals:
//   start        request pulse
//   A, B, bin    16-bit minuend, 16-bit subtrahend, borrow-in
//   D, bout      16-bit difference, borrow-out
//   busy, done   operation in progress, one-cycle completion pulse
//   ovf          signed overflow, present only when SEQ_SUB_OVF_EN is defined
// Modports: master drives the request side, slave is the subtractor.
interface seq_sub_16_if;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        bin;
    logic [15:0] D;
    logic        bout;
    logic        busy;
    logic        done;
`ifdef SEQ_SUB_OVF_EN
    logic        ovf;

    modport master (output start, A, B, bin, input D, bout, busy, done, ovf);
    modport slave  (input start, A, B, bin, output D, bout, busy, done, ovf);
`else
    modport master (output start, A, B, bin, input D, bout, busy, done);
    modport slave  (input start, A, B, bin, output D, bout, busy, done);
`endif
endinterface

// File: rtl/seq_sub_16.sv
// rtl/seq_sub_16.sv - 16-bit sequential subtractor, one 4-bit slice per clock
//
// Computes D = (A - B - bin) mod 2^16 and bout = (A < B + bin) over four
// cycles behind a start/busy/done handshake.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seq_sub_16_if.slave (start, A, B, bin in; D, bout, busy, done out)
// Option macro: SEQ_SUB_OVF_EN adds bus.ovf, the signed two's-complement
// overflow flag, registered and updated together with D.
module seq_sub_16 (
    input  logic          clk,
    input  logic          rst_n,
    seq_sub_16_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        busy_q;
    logic        busy_nxt;
    logic        done_q;
    logic        done_nxt;
    logic        load;

    // Operands shift right one nibble per RUN cycle so the active slice is
    // always in bits [3:0]; the partial result fills from the top.
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [11:0] res_q;
    logic [1:0]  k_q;
    logic        borrow_q;
    logic [15:0] d_q;
    logic        bout_q;
    logic [4:0]  diff;
    logic        last;

    // 5-bit subtraction; bit 4 is the borrow out of this slice.
    assign diff = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'd0, borrow_q};
    assign last = (k_q == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    busy_nxt  = 1'b1;
                    load      = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                // start is deliberately not looked at here
                if (last) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else begin
                    busy_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SEQ_SUB_OVF_EN
    logic ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= 16'd0;
            b_q      <= 16'd0;
            res_q    <= 12'd0;
            k_q      <= 2'd0;
            borrow_q <= 1'b0;
            d_q      <= 16'd0;
            bout_q   <= 1'b0;
`ifdef SEQ_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else if (load) begin
            a_q      <= bus.A;
            b_q      <= bus.B;
            borrow_q <= bus.bin;
            k_q      <= 2'd0;
        end else if (state == RUN) begin
            a_q      <= {4'd0, a_q[15:4]};
            b_q      <= {4'd0, b_q[15:4]};
            res_q    <= {diff[3:0], res_q[11:4]};
            borrow_q <= diff[4];
            k_q      <= k_q + 2'd1;
            if (last) begin
                d_q    <= {diff[3:0], res_q};
                bout_q <= diff[4];
`ifdef SEQ_SUB_OVF_EN
                // On the last slice a_q[3]/b_q[3] hold the original sign bits.
                ovf_q  <= (a_q[3] != b_q[3]) && (diff[3] != a_q[3]);
`endif
            end
        end
    end

    assign bus.D    = d_q;
    assign bus.bout = bout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
`ifdef SEQ_SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_seq_sub_16.sv
// tb/tb_seq_sub_16.sv - self-checking bench for seq_sub_16
module tb_seq_sub_16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_sub_16_if bus ();

    seq_sub_16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int cyc      = 0;
    int last_done_cyc = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bi;
        logic [15:0] d;
        logic        bo;
        logic        ov;
    } vec_t;

    vec_t tbl[9];

    always @(posedge clk) cyc <= cyc + 1;

    // Done pulse counter plus a per-cycle check that busy and done never overlap.
    always @(negedge clk) begin
        if (bus.done) n_done++;
        n_assert++;
        if (bus.busy && bus.done) begin
            n_fail++;
            $display("FAIL busy_done_overlap: busy=%0b done=%0b required not both 1", bus.busy, bus.done);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic bi,
                                  output logic [15:0] d, output logic bo, output logic ov);
        int diff;
        diff = int'(a) - int'(b) - int'(bi);
        bo   = (diff < 0);
        d    = 16'(diff);
        ov   = (a[15] != b[15]) && (d[15] != a[15]);
    endfunction

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                         input logic [15:0] ed, input logic eb, input logic eo,
                         input string tag, input bit pulse_chk);
        int lat;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.bin   = bi;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A     = 16'($urandom);
        bus.B     = 16'($urandom);
        bus.bin   = 1'($urandom);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        lat = 0;
        while (!bus.done && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        last_done_cyc = cyc;
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_D"}, 32'(bus.D), 32'(ed));
        chk({tag, "_bout"}, 32'(bus.bout), 32'(eb));
`ifdef SEQ_SUB_OVF_EN
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
`else
        if (eo !== 1'b0 && eo !== 1'b1) $display("note: ovf expectation undefined for %s", tag);
`endif
        if (pulse_chk) begin
            @(posedge clk);
            #1;
            chk({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
            chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
            chk({tag, "_D_hold"}, 32'(bus.D), 32'(ed));
        end
    endtask

    initial begin
        logic [15:0] ra, rb, ed;
        logic        rbi, eb, eo;
        int          c1, d0;

        tbl[0] = '{16'd65000, 16'd65340, 1'b0, 16'd65196, 1'b1, 1'b0};
        tbl[1] = '{16'd61727, 16'd3592,  1'b0, 16'd58135, 1'b0, 1'b0};
        tbl[2] = '{16'd1075,  16'd69,    1'b1, 16'd1005,  1'b0, 1'b0};
        tbl[3] = '{16'd0,     16'd0,     1'b1, 16'd65535, 1'b1, 1'b0};
        tbl[4] = '{16'd20508, 16'd5383,  1'b1, 16'd15124, 1'b0, 1'b0};
        tbl[5] = '{16'h8000,  16'h0001,  1'b0, 16'h7FFF,  1'b0, 1'b1};
        tbl[6] = '{16'h0005,  16'h0003,  1'b0, 16'h0002,  1'b0, 1'b0};
        tbl[7] = '{16'hFFFF,  16'hFFFF,  1'b1, 16'hFFFF,  1'b1, 1'b0};
        tbl[8] = '{16'h7FFF,  16'hFFFF,  1'b0, 16'h8000,  1'b1, 1'b1};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.A     = 16'd0;
        bus.B     = 16'd0;
        bus.bin   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_D", 32'(bus.D), 32'd0);
        chk("rst_bout", 32'(bus.bout), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].bi, tbl[i].d, tbl[i].bo, tbl[i].ov,
                  $sformatf("vec%0d", i), 1'b1);
        end

        // Back-to-back: start held in the done cycle.
        do_op(16'd61727, 16'd3592, 1'b0, 16'd58135, 1'b0, 1'b0, "b2b_first", 1'b0);
        c1 = last_done_cyc;
        do_op(16'd1075, 16'd69, 1'b1, 16'd1005, 1'b0, 1'b0, "b2b_second", 1'b1);
        chk("b2b_gap", 32'(last_done_cyc - c1), 32'd5);

        // start during RUN is ignored.
        d0 = n_done;
        @(negedge clk);
        bus.start = 1'b1; bus.A = 16'd20508; bus.B = 16'd5383; bus.bin = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.A = 16'd1; bus.B = 16'd1; bus.bin = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("ign_done_count", 32'(n_done - d0), 32'd1);
        chk("ign_D", 32'(bus.D), 32'd15124);
        chk("ign_bout", 32'(bus.bout), 32'd0);

        // Reset mid-RUN aborts with no done.
        @(negedge clk);
        bus.start = 1'b1; bus.A = 16'd50; bus.B = 16'd10024; bus.bin = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_D", 32'(bus.D), 32'd0);
        chk("abort_bout", 32'(bus.bout), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = n_done;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(n_done - d0), 32'd0);
        chk("abort_idle_busy", 32'(bus.busy), 32'd0);
        chk("abort_D_held", 32'(bus.D), 32'd0);
        do_op(16'd50, 16'd10024, 1'b0, 16'd55562, 1'b1, 1'b0, "after_abort", 1'b1);

        // Randomized operations against the integer model, some back-to-back.
        for (int i = 0; i < 40; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rbi = 1'($urandom);
            if (i % 8 == 0) rb = ra;
            model(ra, rb, rbi, ed, eb, eo);
            do_op(ra, rb, rbi, ed, eb, eo, $sformatf("rnd%0d", i), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
